shift_reg_param: RTL

Parametrised universal shift register, the successor to the fixed 32-bit / 8-slice register. Width and slice size are generic. It adds an arithmetic-shift mode and a counted-burst engine: a START pulse runs STEPS operations autonomously and then reports DONE. It sits where the 32-bit register sits today and is driven by the same CLK/ENB/DIR/S_IN/MODO/D bench signals, plus START/STEPS.

---
 rtl/shift_reg_pkg.sv | 18 +
 rtl/shift_reg_param_slice.sv | 39 +++
 rtl/shift_reg_param.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode/direction encodings and FSM state type for shift_reg_param
package shift_reg_pkg;

    localparam logic [1:0] MODO_00 = 2'b00;   // shift with serial fill
    localparam logic [1:0] MODO_01 = 2'b01;   // rotate
    localparam logic [1:0] MODO_10 = 2'b10;   // parallel load
    localparam logic [1:0] MODO_11 = 2'b11;   // arithmetic shift

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_reg_param_slice.sv
// rtl/shift_reg_param_slice.sv - one SLICE-wide segment: next value and the bit it shifts out
module shift_slice
    import shift_reg_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] q_i,
    input  logic [SLICE-1:0] d_i,
    input  logic [1:0]       modo_i,
    input  logic             dir_i,
    input  logic             left_in_i,
    input  logic             right_in_i,
    output logic [SLICE-1:0] q_o,
    output logic             s_out_o
);

    // Extended vectors keep the slicing legal even for SLICE == 1.
    logic [SLICE:0] ext_l;
    logic [SLICE:0] ext_r;

    assign ext_l = {q_i, left_in_i};
    assign ext_r = {right_in_i, q_i};

    always_comb begin
        q_o     = q_i;
        s_out_o = 1'b0;
        if (modo_i == MODO_10) begin
            q_o     = d_i;
            s_out_o = 1'b0;
        end else if (dir_i == DIR_LEFT) begin
            q_o     = ext_l[SLICE-1:0];
            s_out_o = q_i[SLICE-1];
        end else begin
            q_o     = ext_r[SLICE:1];
            s_out_o = q_i[0];
        end
    end

endmodule

// File: rtl/shift_reg_param.sv
// rtl/shift_reg_param.sv - universal shift register with counted-burst engine; SHIFT_REG_PARITY_EN adds PAR
module shift_reg_param
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4,
    parameter int CNT_W = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ENB,
    input  logic                   DIR,
    input  logic                   S_IN,
    input  logic [1:0]             MODO,
    input  logic [WIDTH-1:0]       D,
    input  logic                   START,
    input  logic [CNT_W-1:0]       STEPS,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH/SLICE-1:0] S_OUT,
    output logic                   BUSY,
    output logic                   DONE
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic                   PAR
`endif
);

    localparam int NS = WIDTH / SLICE;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         modo_q, modo_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   q_q;
    logic [NS-1:0]      s_out_q;

    logic               op_en;
    logic [1:0]         op_modo;
    logic               op_dir;
    logic               fill_lo;
    logic               fill_hi;
    logic [WIDTH-1:0]   q_nxt;
    logic [NS-1:0]      s_out_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        modo_d  = modo_q;
        dir_d   = dir_q;
        op_en   = 1'b0;
        op_modo = MODO;
        op_dir  = DIR;
        case (state_q)
            IDLE: begin
                if (START) begin
                    modo_d  = MODO;
                    dir_d   = DIR;
                    cnt_d   = STEPS;
                    state_d = (STEPS == '0) ? FIN : RUN;
                end else if (ENB) begin
                    op_en = 1'b1;
                end
            end
            RUN: begin
                op_en   = 1'b1;
                op_modo = modo_q;
                op_dir  = dir_q;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bits entering the register ends: serial input, wrap-around, or sign/zero fill.
    always_comb begin
        fill_lo = 1'b0;
        fill_hi = 1'b0;
        case (op_modo)
            MODO_00: begin
                fill_lo = S_IN;
                fill_hi = S_IN;
            end
            MODO_01: begin
                fill_lo = q_q[WIDTH-1];
                fill_hi = q_q[0];
            end
            MODO_11: begin
                fill_lo = 1'b0;
                fill_hi = q_q[WIDTH-1];
            end
            default: begin
                fill_lo = 1'b0;
                fill_hi = 1'b0;
            end
        endcase
    end

    for (genvar k = 0; k < NS; k++) begin : g_slice
        logic left_in;
        logic right_in;

        if (k == 0) begin : g_lo
            assign left_in = fill_lo;
        end else begin : g_lo
            assign left_in = q_q[k*SLICE-1];
        end

        if (k == NS-1) begin : g_hi
            assign right_in = fill_hi;
        end else begin : g_hi
            assign right_in = q_q[(k+1)*SLICE];
        end

        shift_slice #(.SLICE(SLICE)) u_slice (
            .q_i        (q_q[k*SLICE +: SLICE]),
            .d_i        (D[k*SLICE +: SLICE]),
            .modo_i     (op_modo),
            .dir_i      (op_dir),
            .left_in_i  (left_in),
            .right_in_i (right_in),
            .q_o        (q_nxt[k*SLICE +: SLICE]),
            .s_out_o    (s_out_nxt[k])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            modo_q  <= MODO_00;
            dir_q   <= DIR_LEFT;
            q_q     <= '0;
            s_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            modo_q  <= modo_d;
            dir_q   <= dir_d;
            if (op_en) begin
                q_q     <= q_nxt;
                s_out_q <= s_out_nxt;
            end
        end
    end

`ifdef SHIFT_REG_PARITY_EN
    logic par_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_q <= 1'b0;
        end else begin
            par_q <= op_en ? ^q_nxt : ^q_q;
        end
    end

    assign PAR = par_q;
`endif

    assign Q     = q_q;
    assign S_OUT = s_out_q;
    assign BUSY  = (state_q == RUN);
    assign DONE  = (state_q == FIN);

endmodule
